// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision FP execution unit.
// Holds the FSM state enum, the unpacked-operand struct and the unpack helper.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_EXEC,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_INF,
    SP_NAN
  } special_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_operand_t;

  // Subnormals are folded into zero here, so later stages never see them.
  function automatic fp_operand_t unpack_fp(input logic [31:0] x);
    fp_operand_t      r;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e         = x[MAN_W +: EXP_W];
    m         = x[MAN_W-1:0];
    r.sign    = x[31];
    r.exp     = e;
    r.is_zero = (e == '0);
    r.is_inf  = (e == '1) && (m == '0);
    r.is_nan  = (e == '1) && (m != '0);
    r.sig     = (e == '0) ? '0 : {1'b1, m};
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational 48-bit leading-zero counter; returns 48 for an all-zero input.
// Counts per byte first, then picks the most significant non-empty byte.
module fp_lzc (
  input  logic [47:0] x,
  output logic [5:0]  count
);

  logic [5:0] grp_zero;
  logic [2:0] grp_cnt [6];

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_grp
      logic [2:0] cnt;
      always_comb begin
        cnt = 3'd0;
        for (int i = 0; i < 8; i++) begin
          if (x[gi*8 + i]) cnt = 3'(7 - i);
        end
      end
      assign grp_cnt[gi]  = cnt;
      assign grp_zero[gi] = ~|x[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    count = 6'd48;
    for (int g = 0; g < 6; g++) begin
      if (!grp_zero[g]) count = 6'(8 * (5 - g)) + {3'b000, grp_cnt[g]};
    end
  end

endmodule

// File: rtl/fp_unit.sv
// Multi-cycle binary32 add/multiply unit with start/finish handshake.
// Datapath stages follow the FSM: capture, unpack, exec, normalize, round.
module fp_unit
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  input  logic        multiplicando,
  output logic [31:0] s,
  output logic        finish
);

  state_t state_reg, state_next;

  logic [31:0]        a_reg, b_reg;
  logic               mul_reg;
  fp_operand_t        ua_reg, ub_reg;
  logic [47:0]        sig_reg;
  logic signed [11:0] exp_reg;
  logic               sign_reg;
  special_t           spec_reg;
  logic [47:0]        norm_sig_reg;
  logic signed [11:0] norm_exp_reg;
  logic [31:0]        s_reg;
  logic               finish_reg;

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_UNPACK;
      ST_UNPACK: state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_NORM;
      ST_NORM:   state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------- EXEC combinational ----------------
  logic               a_big;
  logic               big_sign, small_sign;
  logic [7:0]         big_exp, small_exp, exp_diff;
  logic [23:0]        big_sig, small_sig;
  logic [6:0]         shamt;
  logic [71:0]        align_ext;
  logic [47:0]        small_aligned, big_aligned, add_sum, mul_prod;
  logic               eff_sub;
  logic [47:0]        exec_sig;
  logic signed [11:0] exec_exp;
  logic               exec_sign;
  special_t           exec_spec;

  always_comb begin
    a_big      = {ua_reg.exp, ua_reg.sig} >= {ub_reg.exp, ub_reg.sig};
    big_sign   = a_big ? ua_reg.sign : ub_reg.sign;
    big_exp    = a_big ? ua_reg.exp  : ub_reg.exp;
    big_sig    = a_big ? ua_reg.sig  : ub_reg.sig;
    small_sign = a_big ? ub_reg.sign : ua_reg.sign;
    small_exp  = a_big ? ub_reg.exp  : ua_reg.exp;
    small_sig  = a_big ? ub_reg.sig  : ua_reg.sig;

    // Shifts past 50 already push every significand bit into the sticky field.
    exp_diff      = big_exp - small_exp;
    shamt         = (exp_diff > 8'd50) ? 7'd50 : exp_diff[6:0];
    align_ext     = {1'b0, small_sig, 47'b0} >> shamt;
    small_aligned = align_ext[71:24] | {47'b0, |align_ext[23:0]};
    big_aligned   = {1'b0, big_sig, 23'b0};
    eff_sub       = big_sign ^ small_sign;
    add_sum       = eff_sub ? (big_aligned - small_aligned) : (big_aligned + small_aligned);

    mul_prod = {24'b0, ua_reg.sig} * {24'b0, ub_reg.sig};

    exec_sig  = add_sum;
    exec_exp  = $signed({4'b0, big_exp});
    exec_sign = (add_sum == '0 && eff_sub) ? 1'b0 : big_sign;
    exec_spec = SP_NONE;

    if (mul_reg) begin
      exec_sig  = mul_prod;
      exec_exp  = $signed({4'b0, ua_reg.exp}) + $signed({4'b0, ub_reg.exp}) - $signed(12'(BIAS));
      exec_sign = ua_reg.sign ^ ub_reg.sign;
      if (ua_reg.is_nan || ub_reg.is_nan ||
          (ua_reg.is_inf && ub_reg.is_zero) || (ub_reg.is_inf && ua_reg.is_zero))
        exec_spec = SP_NAN;
      else if (ua_reg.is_inf || ub_reg.is_inf)
        exec_spec = SP_INF;
    end else begin
      if (ua_reg.is_nan || ub_reg.is_nan ||
          (ua_reg.is_inf && ub_reg.is_inf && (ua_reg.sign != ub_reg.sign)))
        exec_spec = SP_NAN;
      else if (ua_reg.is_inf || ub_reg.is_inf) begin
        exec_spec = SP_INF;
        exec_sign = ua_reg.is_inf ? ua_reg.sign : ub_reg.sign;
      end
    end
  end

  // ---------------- NORM combinational ----------------
  logic [5:0]         lz;
  logic [47:0]        norm_sig;
  logic signed [11:0] norm_exp;

  fp_lzc u_lzc (
    .x     (sig_reg),
    .count (lz)
  );

  // sig_reg bit 46 carries weight 2^(exp-127); the leading one ends up at bit 47.
  always_comb begin
    norm_sig = sig_reg << lz;
    norm_exp = exp_reg + 12'sd1 - $signed({6'b0, lz});
  end

  // ---------------- ROUND combinational ----------------
  logic               round_up;
  logic [24:0]        mant_rnd;
  logic signed [11:0] rnd_exp;
  logic [22:0]        frac;
  logic [31:0]        round_result;

  always_comb begin
    round_up = norm_sig_reg[23] & ((|norm_sig_reg[22:0]) | norm_sig_reg[24]);
    mant_rnd = {1'b0, norm_sig_reg[47:24]} + {24'b0, round_up};
    rnd_exp  = norm_exp_reg + $signed({11'b0, mant_rnd[24]});
    frac     = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];

    if (spec_reg == SP_NAN)
      round_result = QNAN;
    else if (spec_reg == SP_INF)
      round_result = sign_reg ? NEG_INF : POS_INF;
    else if (norm_sig_reg == '0)
      round_result = {sign_reg, 31'b0};
    else if (rnd_exp >= 12'sd255)
      round_result = sign_reg ? NEG_INF : POS_INF;
    else if (rnd_exp <= 12'sd0)
      round_result = {sign_reg, 31'b0};
    else
      round_result = {sign_reg, rnd_exp[7:0], frac};
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      s_reg      <= '0;
      finish_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      finish_reg <= (state_reg == ST_ROUND);
      if (state_reg == ST_ROUND) s_reg <= round_result;
    end
  end

  always_ff @(posedge clk) begin
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_reg   <= a;
          b_reg   <= b;
          mul_reg <= multiplicando;
        end
      end
      ST_UNPACK: begin
        ua_reg <= unpack_fp(a_reg);
        ub_reg <= unpack_fp(b_reg);
      end
      ST_EXEC: begin
        sig_reg  <= exec_sig;
        exp_reg  <= exec_exp;
        sign_reg <= exec_sign;
        spec_reg <= exec_spec;
      end
      ST_NORM: begin
        norm_sig_reg <= norm_sig;
        norm_exp_reg <= norm_exp;
      end
      default: ;
    endcase
  end

  assign s      = s_reg;
  assign finish = finish_reg;

endmodule

// File: tb/tb_fp_unit.sv
// Directed bench for fp_unit: expected results queue up at issue time and are
// popped and compared when finish pulses.
module tb_fp_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        start, multiplicando;
  logic [31:0] s;
  logic        finish;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  fp_unit dut (
    .clk           (clk),
    .rst           (rst),
    .a             (a),
    .b             (b),
    .start         (start),
    .multiplicando (multiplicando),
    .s             (s),
    .finish        (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic m,
                       input logic [31:0] e);
    @(negedge clk);
    a = ta; b = tb_v; multiplicando = m; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int lat, input bit drop_start);
    int          n;
    logic [31:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (finish !== 1'b1 && n < 20);
    if (drop_start) start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check({tag, "_s"}, s, e);
    $display("txn %s s=0x%08h expected=0x%08h cycles=%0d", tag, s, e, n);
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, finish}, 32'h0);
  endtask

  initial begin
    bit saw_finish;
    rst = 1'b1; a = '0; b = '0; start = 1'b0; multiplicando = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_s", s, 32'h0);
    check("reset_finish", {31'b0, finish}, 32'h0);
    rst = 1'b0;

    issue(32'hC0200000, 32'hC0400000, 1'b1, 32'h40F00000);
    expect_result("mul_neg", 4, 1'b0);

    // start held high: back-to-back operations every 6 cycles
    @(negedge clk);
    a = 32'hC0200000; b = 32'hC0400000; multiplicando = 1'b1; start = 1'b1;
    exp_q.push_back(32'h40F00000);
    exp_q.push_back(32'h40F00000);
    expect_result("hold_first", 5, 1'b0);
    expect_result("hold_second", 5, 1'b1);

    issue(32'hC0200000, 32'hC0400000, 1'b0, 32'hC0B00000);
    expect_result("add_neg", 4, 1'b0);
    issue(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000);
    expect_result("add_cancel", 4, 1'b0);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    expect_result("tie_even_down", 4, 1'b0);
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    expect_result("tie_even_up", 4, 1'b0);
    issue(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000);
    expect_result("inf_times_zero", 4, 1'b0);
    issue(32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000);
    expect_result("mul_overflow", 4, 1'b0);
    issue(32'h00800000, 32'h00800000, 1'b1, 32'h00000000);
    expect_result("mul_underflow", 4, 1'b0);
    issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    expect_result("nan_add", 4, 1'b0);

    // abort during EXEC: no finish, s cleared
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; multiplicando = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_finish = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (finish === 1'b1) saw_finish = 1'b1;
      @(negedge clk);
    end
    check("abort_no_finish", {31'b0, saw_finish}, 32'h0);
    check("abort_s_cleared", s, 32'h0);
    $display("txn abort s=0x%08h finish_seen=%0b", s, saw_finish);

    // operands disturbed right after capture must not matter
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; multiplicando = 1'b0; start = 1'b1;
    exp_q.push_back(32'h40400000);
    @(negedge clk);
    start = 1'b0; a = 32'hFFFFFFFF; b = 32'h12345678; multiplicando = 1'b1;
    expect_result("after_reset_capture", 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
